// File: rtl/msu_audio_vol.sv
// MSU-1 volume stage: ramps the applied gain toward the latched volume one
// step per accepted sample and scales the signed stereo PCM stream with it.
module msu_audio_vol #(
  parameter int unsigned RAMP_STEP = 1
) (
  input  logic        clkin,
  input  logic        reset_n,
  input  logic [7:0]  volume_in,
  input  logic        volume_latch_in,
  input  logic        mute_in,
  input  logic        sample_in_valid,
  input  logic [15:0] sample_l_in,
  input  logic [15:0] sample_r_in,
  output logic        sample_out_valid,
  output logic [15:0] sample_l_out,
  output logic [15:0] sample_r_out,
  output logic [7:0]  vol_current_out,
  output logic        ramp_busy_out
);

  localparam logic [8:0] STEP9 = 9'(RAMP_STEP);

  logic [7:0]  target_q, target_d;
  logic [7:0]  current_q, current_d;
  logic        latch_q;
  logic        busy_q;

  logic        s1Valid_q;
  logic [15:0] s1L_q, s1R_q;
  logic [8:0]  s1Gain_q;
  logic [8:0]  gain_d;

  logic        outValid_q;
  logic [15:0] outL_q, outR_q;

  logic        latchEdge;
  logic [8:0]  curUp, tgtPlusStep;
  logic [7:0]  rampNext;
  logic signed [24:0] prodL, prodR;
  logic        unusedProdBits;

  assign latchEdge   = volume_latch_in & ~latch_q;
  assign curUp       = {1'b0, current_q} + STEP9;
  assign tgtPlusStep = {1'b0, target_q} + STEP9;

  // Next ramp value and target; the step always aims at the old target
  always_comb begin
    rampNext = current_q;
    if (current_q < target_q) begin
      if (curUp >= {1'b0, target_q}) rampNext = target_q;
      else                           rampNext = curUp[7:0];
    end else if (current_q > target_q) begin
      if ({1'b0, current_q} <= tgtPlusStep) rampNext = target_q;
      else                                  rampNext = current_q - STEP9[7:0];
    end
    current_d = sample_in_valid ? rampNext : current_q;
    target_d  = latchEdge ? volume_in : target_q;
    gain_d    = mute_in ? 9'd0 : ({1'b0, current_q} + {8'd0, current_q[7]});
  end

  // Volume state: latch edge detect, target capture, ramp, busy flag
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      target_q  <= 8'hFF;
      current_q <= 8'hFF;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      target_q  <= target_d;
      current_q <= current_d;
      latch_q   <= volume_latch_in;
      busy_q    <= (current_q != target_q);
    end
  end

  // Stage 1: capture samples together with the gain in force at acceptance
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      s1Valid_q <= 1'b0;
      s1L_q     <= 16'd0;
      s1R_q     <= 16'd0;
      s1Gain_q  <= 9'd0;
    end else begin
      s1Valid_q <= sample_in_valid;
      if (sample_in_valid) begin
        s1L_q    <= sample_l_in;
        s1R_q    <= sample_r_in;
        s1Gain_q <= gain_d;
      end
    end
  end

  // Signed 25-bit product; gain of at most 256 keeps the shifted result in 16 bits
  always_comb begin
    prodL = $signed({{9{s1L_q[15]}}, s1L_q}) * $signed({16'd0, s1Gain_q});
    prodR = $signed({{9{s1R_q[15]}}, s1R_q}) * $signed({16'd0, s1Gain_q});
  end

  assign unusedProdBits = ^{prodL[24], prodL[7:0], prodR[24], prodR[7:0]};

  // Stage 2: arithmetic shift by 8 into held output registers
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      outValid_q <= 1'b0;
      outL_q     <= 16'd0;
      outR_q     <= 16'd0;
    end else begin
      outValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        outL_q <= prodL[23:8];
        outR_q <= prodR[23:8];
      end
    end
  end

  assign sample_out_valid = outValid_q;
  assign sample_l_out     = outL_q;
  assign sample_r_out     = outR_q;
  assign vol_current_out  = current_q;
  assign ramp_busy_out    = busy_q;

endmodule

// File: tb/tb_msu_audio_vol.sv
// Bench for msu_audio_vol: two instances (ramp step 1 and 4) share one
// stimulus stream and are compared against an arithmetic reference model.
module tb_msu_audio_vol;

  logic        clkin;
  logic        resetN;
  logic [7:0]  volumeIn;
  logic        volumeLatchIn;
  logic        muteIn;
  logic        sampleInValid;
  logic [15:0] sampleLIn;
  logic [15:0] sampleRIn;

  logic        outValid [2];
  logic [15:0] lOut [2];
  logic [15:0] rOut [2];
  logic [7:0]  volCur [2];
  logic        busy [2];

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  typedef struct {
    int               due;
    logic [1:0][15:0] l;
    logic [1:0][15:0] r;
  } expEntry_t;

  expEntry_t   expQ[$];
  int          curM [2];
  int          tgtM [2];
  logic [15:0] lastL [2];
  logic [15:0] lastR [2];
  bit          busyPre [2];
  bit          busyPost [2];
  bit          prevLat;

  msu_audio_vol #(.RAMP_STEP(1)) dutA (
    .clkin(clkin), .reset_n(resetN), .volume_in(volumeIn),
    .volume_latch_in(volumeLatchIn), .mute_in(muteIn),
    .sample_in_valid(sampleInValid), .sample_l_in(sampleLIn), .sample_r_in(sampleRIn),
    .sample_out_valid(outValid[0]), .sample_l_out(lOut[0]), .sample_r_out(rOut[0]),
    .vol_current_out(volCur[0]), .ramp_busy_out(busy[0])
  );

  msu_audio_vol #(.RAMP_STEP(4)) dutB (
    .clkin(clkin), .reset_n(resetN), .volume_in(volumeIn),
    .volume_latch_in(volumeLatchIn), .mute_in(muteIn),
    .sample_in_valid(sampleInValid), .sample_l_in(sampleLIn), .sample_r_in(sampleRIn),
    .sample_out_valid(outValid[1]), .sample_l_out(lOut[1]), .sample_r_out(rOut[1]),
    .vol_current_out(volCur[1]), .ramp_busy_out(busy[1])
  );

  // Free-running 10-unit clock
  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  function automatic int stepOf(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // Floor of sample*gain/256, done with ordinary integer arithmetic
  function automatic logic [15:0] scaleSample(logic [15:0] s, int gain);
    int p;
    int q;
    p = int'($signed(s)) * gain;
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    return 16'(q);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cycle, obs, expv);
    end
  endtask

  task automatic modelReset();
    expQ.delete();
    prevLat = 1'b0;
    for (int i = 0; i < 2; i++) begin
      curM[i] = 255; tgtM[i] = 255;
      lastL[i] = 16'd0; lastR[i] = 16'd0;
      busyPre[i] = 1'b0; busyPost[i] = 1'b0;
    end
  endtask

  // Reference behaviour for one clock edge given the inputs in front of it
  task automatic modelStep(input bit v, input logic [15:0] sl, input logic [15:0] sr,
                           input bit lat, input logic [7:0] vol, input bit mu);
    expEntry_t e;
    bit rise;
    int gain;
    rise = lat && !prevLat;
    for (int i = 0; i < 2; i++) busyPre[i] = (curM[i] != tgtM[i]);
    if (v) begin
      e.due = cycle + 2;
      for (int i = 0; i < 2; i++) begin
        gain = mu ? 0 : curM[i] + ((curM[i] >= 128) ? 1 : 0);
        e.l[i] = scaleSample(sl, gain);
        e.r[i] = scaleSample(sr, gain);
        if (curM[i] < tgtM[i])      curM[i] = (curM[i] + stepOf(i) > tgtM[i]) ? tgtM[i] : curM[i] + stepOf(i);
        else if (curM[i] > tgtM[i]) curM[i] = (curM[i] - stepOf(i) < tgtM[i]) ? tgtM[i] : curM[i] - stepOf(i);
      end
      expQ.push_back(e);
    end
    if (rise) for (int i = 0; i < 2; i++) tgtM[i] = int'(vol);
    prevLat = lat;
    for (int i = 0; i < 2; i++) busyPost[i] = (curM[i] != tgtM[i]);
  endtask

  // Compare every output of both instances against the model
  task automatic verifyCycle();
    bit expV;
    expEntry_t e;
    expV = (expQ.size() > 0) && (expQ[0].due == cycle);
    if (expV) begin
      e = expQ.pop_front();
      for (int i = 0; i < 2; i++) begin
        lastL[i] = e.l[i];
        lastR[i] = e.r[i];
      end
    end
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("valid%0d", i), 32'(outValid[i]), 32'(expV));
      checkOutput($sformatf("left%0d", i), 32'(lOut[i]), 32'(lastL[i]));
      checkOutput($sformatf("right%0d", i), 32'(rOut[i]), 32'(rastR(i)));
      checkOutput($sformatf("vol%0d", i), 32'(volCur[i]), 32'(curM[i]));
      if (busyPre[i] == busyPost[i])
        checkOutput($sformatf("busy%0d", i), 32'(busy[i]), 32'(busyPost[i]));
    end
  endtask

  function automatic logic [15:0] rastR(int i);
    return lastR[i];
  endfunction

  // One clock cycle: drive inputs at the falling edge, step the model, check next falling edge
  task automatic applyStimulus(input bit v, input logic [15:0] sl, input logic [15:0] sr,
                               input bit lat, input logic [7:0] vol, input bit mu);
    sampleInValid = v;
    sampleLIn     = sl;
    sampleRIn     = sr;
    volumeLatchIn = lat;
    volumeIn      = vol;
    muteIn        = mu;
    if (resetN) modelStep(v, sl, sr, lat, vol, mu);
    else        modelReset();
    @(posedge clkin);
    cycle++;
    @(negedge clkin);
    verifyCycle();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic randomSamples(input int n, input bit mu);
    for (int k = 0; k < n; k++)
      applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0, 8'($urandom), mu);
  endtask

  task automatic latchVolume(input logic [7:0] vol);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, vol, 1'b0);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    resetN = 1'b0;
    sampleInValid = 1'b0; sampleLIn = 16'd0; sampleRIn = 16'd0;
    volumeLatchIn = 1'b0; volumeIn = 8'd0; muteIn = 1'b0;
    modelReset();
    @(negedge clkin);
    idle(2);
    resetN = 1'b1;

    // Reset state and unity passthrough
    idle(1);
    checkOutput("rstVol", 32'(volCur[0]), 32'h0FF);
    checkOutput("rstBusy", 32'(busy[0]), 32'h0);
    applyStimulus(1'b1, 16'h1234, 16'hEDCC, 1'b0, 8'd0, 1'b0);
    idle(2);
    checkOutput("passL", 32'(lOut[0]), 32'h1234);
    checkOutput("passR", 32'(rOut[0]), 32'hEDCC);

    // Half-scale gain of 129
    latchVolume(8'h80);
    randomSamples(130, 1'b0);
    idle(2);
    checkOutput("settleBusy", 32'(busy[0]), 32'h0);
    applyStimulus(1'b1, 16'h4000, 16'hFFFF, 1'b0, 8'd0, 1'b0);
    idle(2);
    checkOutput("halfL", 32'(lOut[0]), 32'h2040);
    checkOutput("halfR", 32'(rOut[0]), 32'hFFFF);

    // Exact unity at full volume with extreme samples
    latchVolume(8'hFF);
    randomSamples(130, 1'b0);
    applyStimulus(1'b1, 16'h7FFF, 16'h8000, 1'b0, 8'd0, 1'b0);
    idle(2);
    checkOutput("unityL", 32'(lOut[0]), 32'h7FFF);
    checkOutput("unityR", 32'(rOut[1]), 32'h8000);

    // Step-4 ramp down to zero without undershoot
    latchVolume(8'h00);
    for (int k = 1; k <= 64; k++) begin
      applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0, 8'd0, 1'b0);
      checkOutput("rampB", 32'(volCur[1]), 32'((255 - 4 * k) < 0 ? 0 : 255 - 4 * k));
    end
    idle(2);
    checkOutput("rampBusyB", 32'(busy[1]), 32'h0);

    // Latch held high for 10 cycles while the volume changes
    for (int k = 0; k < 10; k++)
      applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, (k == 0) ? 8'h40 : 8'(8'h90 + k), 1'b0);
    idle(1);
    randomSamples(300, 1'b0);
    checkOutput("levelA", 32'(volCur[0]), 32'h40);
    checkOutput("levelB", 32'(volCur[1]), 32'h40);

    // Latch edge coincident with a sample: the sample uses the old gain of 64
    applyStimulus(1'b1, 16'h4000, 16'h4000, 1'b1, 8'hFF, 1'b0);
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 8'd0, 1'b0);
    idle(1);
    checkOutput("collideL", 32'(lOut[0]), 32'h1000);

    // Mute while ramping up from zero
    latchVolume(8'h00);
    randomSamples(300, 1'b0);
    latchVolume(8'h40);
    randomSamples(16, 1'b1);
    idle(2);
    checkOutput("muteVol", 32'(volCur[0]), 32'h10);
    checkOutput("muteL", 32'(lOut[0]), 32'h0);

    // Randomised traffic across valid, latch, volume and mute
    for (int k = 0; k < 1500; k++)
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                    ($urandom_range(0, 9) == 0), 8'($urandom), ($urandom_range(0, 9) == 0));

    // Asynchronous reset with a sample in flight
    idle(3);
    applyStimulus(1'b1, 16'h5555, 16'hAAAA, 1'b0, 8'd0, 1'b0);
    resetN = 1'b0;
    #1;
    checkOutput("arstValid", 32'(outValid[0]), 32'h0);
    checkOutput("arstL", 32'(lOut[0]), 32'h0);
    checkOutput("arstVol", 32'(volCur[1]), 32'h0FF);
    checkOutput("arstBusy", 32'(busy[1]), 32'h0);
    modelReset();
    @(negedge clkin);
    idle(1);
    resetN = 1'b1;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msu_audio_vol.md
# msu_audio_vol

Per-sample MSU-1 volume stage that sits directly downstream of the MSU register block. It consumes that block's 8-bit volume value and volume latch strobe, and ramps the applied gain toward the written volume one step per audio sample to avoid zipper noise. It scales the signed 16-bit stereo PCM stream from the audio fetch path before the stream reaches the DAC serializer.

## Interface
Parameters:
- RAMP_STEP, default 1: gain change per accepted sample, range 1..255.

Ports:
- clkin  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- volume_in  in  8  target volume, driven from the MSU register block's volume_out.
- volume_latch_in  in  1  volume write strobe, driven from volume_latch_out. Level, high for ≥1 cycle per write.
- mute_in  in  1  forces the applied gain to 0 while high.
- sample_in_valid  in  1  one-cycle strobe; sample_l_in/sample_r_in are valid.
- sample_l_in  in  16  signed left PCM sample.
- sample_r_in  in  16  signed right PCM sample.
- sample_out_valid  out  1  one-cycle strobe; scaled outputs are valid.
- sample_l_out  out  16  signed scaled left sample.
- sample_r_out  out  16  signed scaled right sample.
- vol_current_out  out  8  current ramped volume.
- ramp_busy_out  out  1  high while vol_current_out != target.

## Operation
- Registers:
  - target_r[7:0]: the volume being ramped toward.
  - current_r[7:0]: the volume currently applied.
  - latch_d_r: previous value of volume_latch_in.
  - 2-stage data pipeline.
- Volume latch:
  - A rising edge is volume_latch_in=1 while latch_d_r=0.
  - On a rising edge, target_r <= volume_in.
  - A latch held high updates target_r only once.
- Gain:
  - gain[8:0] = {1'b0,current_r} + current_r[7]. This maps 0x00→0, 0x80→129 and 0xFF→256 (exact unity).
  - mute_in=1 at acceptance forces gain = 0.
- Scaling: out = (sample × gain) >>> 8, computed in 25-bit signed arithmetic with an arithmetic shift (rounds toward −∞). The result always fits in 16 bits, so no saturation logic is needed.
- Ramp: on each accepted sample:
  - If current_r < target_r: current_r <= min(current_r + RAMP_STEP, target_r).
  - If current_r > target_r: current_r <= max(current_r − RAMP_STEP, target_r).
  - Otherwise current_r is unchanged.
  - Arithmetic is 9-bit, so no wrap-around is possible.
  - The ramp advances while mute_in is high.
  - With no samples arriving, the ramp does not advance.
- Simultaneous events:
  - A sample accepted in the same cycle as a latch rising edge uses the old current_r for its gain.
  - In that cycle the ramp step is computed against the old target_r.
  - The new target applies from the next accepted sample.
- Reset values (all asserted asynchronously):
  - target_r = current_r = 0xFF, vol_current_out = 0xFF.
  - latch_d_r = 0.
  - sample_out_valid = 0, sample_l_out = sample_r_out = 0.
  - ramp_busy_out = 0.
- Reset mid-operation: samples in flight in the pipeline are dropped and no sample_out_valid is emitted for them.

## Timing
- Pipeline stage 1, on the edge where sample_in_valid=1: register the samples and the gain, and update current_r.
- Pipeline stage 2: multiply and shift into the output registers, and assert sample_out_valid.
- Latency: sample_out_valid rises exactly 2 cycles after sample_in_valid.
- Throughput: one sample per cycle. Back-to-back valids yield back-to-back output valids.
- The outputs hold their values until the next sample_out_valid.
- Latch edge → target_r updated on the same clkin edge. ramp_busy_out reflects it 1 cycle after that edge.
- vol_current_out and ramp_busy_out are registered outputs.

## Test plan
- Reset passthrough: release reset, send L=0x1234/R=0xEDCC → output 2 cycles later is L=0x1234/R=0xEDCC, vol_current_out=0xFF, ramp_busy_out=0.
- Scaling math: latch 0x80, run samples until ramp_busy_out=0, then send L=0x4000/R=0xFFFF → L=0x2040, R=0xFFFF. Then at volume 0xFF send L=0x7FFF/R=0x8000 → outputs are 0x7FFF/0x8000 unchanged.
- Ramp, RAMP_STEP=4: volume 0xFF, latch 0x00, send 64 samples → vol_current_out reads 0xFB, 0xF7, …, 0x03, then 0x00 after sample 64. ramp_busy_out falls after sample 64. No undershoot.
- Level latch and collision:
  - Hold volume_latch_in high for 10 cycles while volume_in changes → only the first-cycle value is latched.
  - Latch edge coincident with sample_in_valid → that sample is scaled with the old gain.
- Mute: mute_in=1 with volume ramping from 0x00 to 0x40, 16 samples → all outputs 0x0000. vol_current_out still reaches 0x10 with RAMP_STEP=1.
- Async reset mid-stream: assert reset_n low between sample_in_valid and the output cycle → no sample_out_valid appears; all outputs go to their reset values immediately.
